// File: rtl/assoc_cache_if.sv
// assoc_cache_if: CPU-side request/response bus and memory-side burst bus of assoc_cache.
interface assoc_cache_if #(parameter int s_offset = 5);
    localparam int s_line = 8 * 2**s_offset;
    logic [31:0] mem_address;
    logic mem_read;
    logic mem_write;
    logic [2**s_offset-1:0] mem_byte_enable256;
    logic [s_line-1:0] mem_wdata256;
    logic [s_line-1:0] mem_rdata256;
    logic mem_resp;
    logic [31:0] pmem_address;
    logic pmem_read;
    logic pmem_write;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic pmem_resp;
    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256, pmem_rdata, pmem_resp,
        input mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
    modport slave (
        input mem_address, mem_read, mem_write, mem_byte_enable256, mem_wdata256, pmem_rdata, pmem_resp,
        output mem_rdata256, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/assoc_cache.sv
// assoc_cache: write-back, write-allocate set-associative cache with tree-PLRU replacement.
// Define ASSOC_CACHE_STATS_EN to build the saturating hit/miss/writeback counters.
module assoc_cache #(
    parameter int s_offset = 5,
    parameter int s_index = 3,
    parameter int num_ways = 4,
    parameter int s_tag = 32 - s_offset - s_index
) (
    input  logic clk,
    input  logic rst,
    assoc_cache_if.slave bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);
    localparam int s_line = 8 * 2**s_offset;
    localparam int s_mask = 2**s_offset;
    localparam int num_sets = 2**s_index;
    localparam int s_way = $clog2(num_ways);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
    state_t state;
    logic [num_ways-1:0] valid [num_sets];
    logic [num_ways-1:0] dirty [num_sets];
    logic [num_ways-2:0] plru [num_sets];
    logic [s_tag-1:0] tags [num_sets][num_ways];
    logic [s_line-1:0] data [num_sets][num_ways];
    logic [31-s_offset:0] req_line;
    logic [s_line-1:0] req_wdata;
    logic [s_mask-1:0] req_be;
    logic req_write;
    logic [s_way-1:0] victim, hit_way, miss_way;
    logic [num_ways-1:0] hits;
    logic [s_line-1:0] merged;
    logic [s_index-1:0] idx;
    logic [s_tag-1:0] tag;
    assign idx = req_line[s_index-1:0];
    assign tag = req_line[31-s_offset -: s_tag];
    // Tree nodes are heap-ordered; level l of the tree decides way bit l (LSB at the root).
    function automatic logic [s_way-1:0] plru_way(input logic [num_ways-2:0] t);
        int n;
        plru_way = '0;
        n = 0;
        for (int l = 0; l < s_way; l++) begin
            plru_way[l] = t[n];
            n = 2 * n + 1 + int'(t[n]);
        end
    endfunction
    function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] t, input logic [s_way-1:0] w);
        int n;
        plru_touch = t;
        n = 0;
        for (int l = 0; l < s_way; l++) begin
            plru_touch[n] = ~w[l];
            n = 2 * n + 1 + int'(w[l]);
        end
    endfunction
    for (genvar w = 0; w < num_ways; w++) begin : g_way
        assign hits[w] = valid[idx][w] && tags[idx][w] == tag;
    end
    always_comb begin
        hit_way = '0;
        miss_way = plru_way(plru[idx]);
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (hits[w]) hit_way = s_way'(w);
            if (!valid[idx][w]) miss_way = s_way'(w);
        end
        merged = data[idx][hit_way];
        for (int b = 0; b < s_mask; b++)
            if (req_write && req_be[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
    end
    always_ff @(posedge clk) begin
        bus.mem_resp <= 1'b0;
        if (rst) begin
            state <= IDLE;
            for (int s = 0; s < num_sets; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s] <= '0;
            end
            bus.mem_rdata256 <= '0;
            bus.pmem_read <= 1'b0;
            bus.pmem_write <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.mem_read || bus.mem_write) begin
                    req_line <= bus.mem_address[31:s_offset];
                    req_wdata <= bus.mem_wdata256;
                    req_be <= bus.mem_byte_enable256;
                    req_write <= bus.mem_write;
                    state <= COMPARE;
                end
                COMPARE: if (|hits) begin
                    bus.mem_resp <= 1'b1;
                    bus.mem_rdata256 <= merged;
                    plru[idx] <= plru_touch(plru[idx], hit_way);
                    if (req_write) data[idx][hit_way] <= merged;
                    if (req_write && |req_be) dirty[idx][hit_way] <= 1'b1;
                    state <= IDLE;
                end else begin
                    victim <= miss_way;
                    if (valid[idx][miss_way] && dirty[idx][miss_way]) begin
                        bus.pmem_write <= 1'b1;
                        bus.pmem_address <= {tags[idx][miss_way], idx, s_offset'(0)};
                        bus.pmem_wdata <= data[idx][miss_way];
                        state <= WRITEBACK;
                    end else begin
                        bus.pmem_read <= 1'b1;
                        bus.pmem_address <= {tag, idx, s_offset'(0)};
                        state <= ALLOCATE;
                    end
                end
                WRITEBACK: if (bus.pmem_resp) begin
                    bus.pmem_write <= 1'b0;
                    bus.pmem_read <= 1'b1;
                    bus.pmem_address <= {tag, idx, s_offset'(0)};
                    state <= ALLOCATE;
                end
                ALLOCATE: if (bus.pmem_resp) begin
                    bus.pmem_read <= 1'b0;
                    data[idx][victim] <= bus.pmem_rdata;
                    tags[idx][victim] <= tag;
                    valid[idx][victim] <= 1'b1;
                    dirty[idx][victim] <= 1'b0;
                    state <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ASSOC_CACHE_STATS_EN
    logic refill;
    always_ff @(posedge clk) begin
        if (rst) begin
            refill <= 1'b0;
            hit_count <= '0;
            miss_count <= '0;
            wb_count <= '0;
        end else begin
            refill <= state == ALLOCATE;
            if (state == COMPARE && |hits && !refill && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (state == COMPARE && !(|hits) && miss_count != '1) miss_count <= miss_count + 32'd1;
            if (state == WRITEBACK && bus.pmem_resp && wb_count != '1) wb_count <= wb_count + 32'd1;
        end
    end
`else
    assign hit_count = '0;
    assign miss_count = '0;
    assign wb_count = '0;
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: randomized bench comparing assoc_cache against a behavioural cache model.
// Counter expectations follow ASSOC_CACHE_STATS_EN.
module tb_assoc_cache;
    localparam int NW = 4;
    localparam int LW = 2;
`ifdef ASSOC_CACHE_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif
    typedef struct packed {logic wr; logic [31:0] addr; logic [255:0] data;} ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] hit_count, miss_count, wb_count;
    assoc_cache_if bus ();
    assoc_cache dut (.clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic m_valid [8][NW];
    logic m_dirty [8][NW];
    logic [23:0] m_tag [8][NW];
    logic [255:0] m_data [8][NW];
    bit pl [8][LW][NW/2];
    logic [255:0] mem [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];
    int exp_hit, exp_miss, exp_wb, mem_lat = 2;
    logic mem_stall = 1'b0, rand_lat = 1'b0, last_miss;
    ev_t got_ev [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] a);
        return a == 32'h40 ? {32{8'hA5}} : {8{a ^ 32'h1357_9BDF}};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_line(a);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        for (int s = 0; s < 8; s++)
            for (int l = 0; l < LW; l++)
                for (int p = 0; p < NW/2; p++) pl[s][l][p] = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        exp_wb = 0;
    endtask

    // Each tree level is indexed by the way bits already chosen above it.
    function automatic int victim_of(input int s);
        int w = 0;
        for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = -1 - i;
        if (w < 0) return -1 - w;
        for (int l = 0; l < LW; l++) w |= int'(pl[s][l][w]) << l;
        return w;
    endfunction

    task automatic touch(input int s, input int w);
        for (int l = 0; l < LW; l++) pl[s][l][w & ((1 << l) - 1)] = ((w >> l) & 1) == 0;
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] be, input logic [255:0] wd);
        int s = int'(addr[7:5]);
        logic [23:0] t = addr[31:8];
        logic [31:0] la = {addr[31:5], 5'd0};
        int w = -1;
        int n;
        ev_t exp_ev [$];
        for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
        last_miss = w < 0;
        if (w < 0) begin
            exp_miss++;
            w = victim_of(s);
            if (m_valid[s][w] && m_dirty[s][w]) begin
                exp_ev.push_back({1'b1, m_tag[s][w], addr[7:5], 5'd0, m_data[s][w]});
                ref_mem[{m_tag[s][w], addr[7:5], 5'd0}] = m_data[s][w];
                exp_wb++;
            end
            exp_ev.push_back({1'b0, la, 256'd0});
            m_valid[s][w] = 1'b1;
            m_dirty[s][w] = 1'b0;
            m_tag[s][w] = t;
            m_data[s][w] = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
        end else exp_hit++;
        touch(s, w);
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
            if (be != 0) m_dirty[s][w] = 1'b1;
        end
        got_ev.delete();
        bus.mem_address = addr;
        bus.mem_write = wr;
        bus.mem_read = !wr || $urandom_range(0, 1) == 1;
        bus.mem_byte_enable256 = be;
        bus.mem_wdata256 = wd;
        step();
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        n = 1;
        while (!bus.mem_resp && n < 200) begin
            step();
            n++;
        end
        check("resp_seen", 256'(bus.mem_resp), 256'd1);
        check("rdata", bus.mem_rdata256, m_data[s][w]);
        if (!last_miss) check("hit_lat", 256'(n), 256'd2);
        check("pm_cnt", 256'(got_ev.size()), 256'(exp_ev.size()));
        foreach (exp_ev[i])
            if (i < got_ev.size()) begin
                check("pm_wr", 256'(got_ev[i].wr), 256'(exp_ev[i].wr));
                check("pm_addr", 256'(got_ev[i].addr), 256'(exp_ev[i].addr));
                check("pm_data", got_ev[i].data, exp_ev[i].data);
            end
        check("hit_count", 256'(hit_count), 256'(stats_en ? exp_hit : 0));
        check("miss_count", 256'(miss_count), 256'(stats_en ? exp_miss : 0));
        check("wb_count", 256'(wb_count), 256'(stats_en ? exp_wb : 0));
        step();
        check("resp_pulse", 256'(bus.mem_resp), 256'd0);
    endtask

    // Memory model: answers each burst after a short delay with a one-cycle pmem_resp.
    initial begin
        int cnt = 0;
        bit busy = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            step();
            check("pm_excl", 256'(bus.pmem_read & bus.pmem_write), 256'd0);
            if (bus.pmem_resp) bus.pmem_resp = 1'b0;
            else if (!rst && !mem_stall && (bus.pmem_read || bus.pmem_write)) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (cnt > 0) cnt--;
                else begin
                    busy = 1'b0;
                    if (bus.pmem_write) begin
                        mem[bus.pmem_address] = bus.pmem_wdata;
                        got_ev.push_back({1'b1, bus.pmem_address, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = mem_line(bus.pmem_address);
                        got_ev.push_back({1'b0, bus.pmem_address, 256'd0});
                    end
                    bus.pmem_resp = 1'b1;
                end
            end else busy = 1'b0;
        end
    end

    initial begin
        logic [255:0] wd;
        logic [31:0] a;
        int n;
        bus.mem_address = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable256 = '0;
        bus.mem_wdata256 = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        check("rst_mem_resp", 256'(bus.mem_resp), 256'd0);
        check("rst_pmem_read", 256'(bus.pmem_read), 256'd0);
        check("rst_pmem_write", 256'(bus.pmem_write), 256'd0);
        check("rst_pmem_address", 256'(bus.pmem_address), 256'd0);
        check("rst_pmem_wdata", bus.pmem_wdata, 256'd0);
        check("rst_rdata", bus.mem_rdata256, 256'd0);
        check("rst_hit_count", 256'(hit_count), 256'd0);
        check("rst_miss_count", 256'(miss_count), 256'd0);
        check("rst_wb_count", 256'(wb_count), 256'd0);
        access(1'b0, 32'h40, '0, '0);
        check("first_read_a5", bus.mem_rdata256, {32{8'hA5}});
        check("first_read_miss", 256'(last_miss), 256'd1);
        access(1'b0, 32'h40, '0, '0);
        check("reread_hit", 256'(last_miss), 256'd0);
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
        wd[31:0] = 32'hDEAD_BEEF;
        access(1'b1, 32'h40, 32'h0000_000F, wd);
        check("write_merge", bus.mem_rdata256, {wd[255:32] ^ wd[255:32] ^ {28{8'hA5}}, 32'hDEAD_BEEF});
        for (int t = 1; t <= NW + 1; t++) access(1'b0, (32'(t) << 8) | 32'h40, '0, '0);
        check("wb_deadbeef", 256'(mem_line(32'h40)), {{28{8'hA5}}, 32'hDEAD_BEEF});
        for (int t = 1; t <= NW; t++) access(1'b0, (32'(t) << 8) | 32'hA0, '0, '0);
        for (int t = 1; t <= 3; t++) access(1'b0, (32'(t) << 8) | 32'hA0, '0, '0);
        access(1'b0, 32'h5A0, '0, '0);
        access(1'b0, 32'h4A0, '0, '0);
        check("plru_evicts_way3", 256'(last_miss), 256'd1);
        rand_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
            access($urandom_range(0, 1) == 1, a, $urandom_range(0, 7) == 0 ? 32'd0 : $urandom, wd);
        end
        mem_stall = 1'b1;
        bus.mem_address = 32'h77C0;
        bus.mem_read = 1'b1;
        step();
        bus.mem_read = 1'b0;
        n = 0;
        while (!bus.pmem_read && n < 20) begin
            step();
            n++;
        end
        check("alloc_read_high", 256'(bus.pmem_read), 256'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_stall = 1'b0;
        check("rst_alloc_read", 256'(bus.pmem_read), 256'd0);
        check("rst_alloc_resp", 256'(bus.mem_resp), 256'd0);
        check("rst_alloc_miss_count", 256'(miss_count), 256'd0);
        model_reset();
        access(1'b0, 32'h77C0, '0, '0);
        check("rst_reread_miss", 256'(last_miss), 256'd1);
        access(1'b0, 32'h40, '0, '0);
        check("rst_lost_valid", 256'(last_miss), 256'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
